// File: rtl/edge_pkg.sv
// Shared definitions for the edge-event path (pulse_train_gen and edge_detector).
// Contents:
//   CNT_W_DEF / NUM_W_DEF : default counter and pulse-index widths.
//   state_t               : pulse_train_gen FSM encoding. 2'd3 is illegal and
//                           recovers to ST_IDLE.
package edge_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int NUM_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_train_gen_if.sv
// Control and status bundle for pulse_train_gen.
// Signals:
//   trig, abort, cfg_width, cfg_gap, cfg_num : master -> generator
//   d, busy, done, pulse_idx, state_dbg      : generator -> master
// Handshake: there is no valid/ready pair. trig is a single-cycle request that
// is taken only when the generator is idle (busy=0, including the done cycle).
// A trig seen while busy is dropped, not queued. abort is a synchronous cancel
// that wins over trig. cfg_* only needs to be stable in the cycle trig is high.
// state_dbg mirrors the FSM register for checkers.
interface pulse_train_gen_if
    import edge_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) ();

    logic             trig;
    logic             abort;
    logic [CNT_W-1:0] cfg_width;
    logic [CNT_W-1:0] cfg_gap;
    logic [NUM_W-1:0] cfg_num;
    logic             d;
    logic             busy;
    logic             done;
    logic [NUM_W-1:0] pulse_idx;
    state_t           state_dbg;

    modport master (
        output trig, abort, cfg_width, cfg_gap, cfg_num,
        input  d, busy, done, pulse_idx, state_dbg
    );

    modport slave (
        input  trig, abort, cfg_width, cfg_gap, cfg_num,
        output d, busy, done, pulse_idx, state_dbg
    );

endinterface

// File: rtl/phase_counter.sv
// Loadable down counter that times one HIGH or LOW phase.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   load       : load load_val (wins over en)
//   en         : decrement by one; holds at zero instead of wrapping
//   load_val   : phase length minus one
//   zero       : counter is currently 0, i.e. this is the phase's last cycle
module phase_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    localparam logic [W-1:0] ONE = 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Burst pulse generator: on an accepted trig, emits cfg_num high pulses of
// max(cfg_width,1) cycles separated by max(cfg_gap,1) low cycles on d.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pulse_train_gen_if slave (trig/abort/cfg_* in,
//                d/busy/done/pulse_idx/state_dbg out, all registered)
module pulse_train_gen
    import edge_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    pulse_train_gen_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [NUM_W-1:0] IDX_ONE = 1;

    state_t           state_q, state_d;
    logic             d_q, d_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [NUM_W-1:0] idx_q, idx_d;
    // Shadow copies of the burst configuration; phase lengths kept as length-1
    // so they load straight into the down counter.
    logic [CNT_W-1:0] wid_m1_q, wid_m1_d;
    logic [CNT_W-1:0] gap_m1_q, gap_m1_d;
    logic [NUM_W-1:0] num_q, num_d;

    logic [CNT_W-1:0] cfg_wid_m1;
    logic [CNT_W-1:0] cfg_gap_m1;
    logic             cnt_load;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;

    // A zero width or gap behaves as one cycle.
    assign cfg_wid_m1 = (bus.cfg_width == '0) ? '0 : bus.cfg_width - CNT_ONE;
    assign cfg_gap_m1 = (bus.cfg_gap   == '0) ? '0 : bus.cfg_gap   - CNT_ONE;

    phase_counter #(.W(CNT_W)) u_phase_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        d_d          = d_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        idx_d        = idx_q;
        wid_m1_d     = wid_m1_q;
        gap_m1_d     = gap_m1_q;
        num_d        = num_q;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
        cnt_load_val = wid_m1_q;

        if (bus.abort) begin
            // pulse_idx deliberately holds so the aborted position stays visible.
            state_d = ST_IDLE;
            d_d     = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.trig) begin
                        wid_m1_d = cfg_wid_m1;
                        gap_m1_d = cfg_gap_m1;
                        num_d    = bus.cfg_num;
                        if (bus.cfg_num == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d      = ST_HIGH;
                            d_d          = 1'b1;
                            busy_d       = 1'b1;
                            idx_d        = '0;
                            cnt_load     = 1'b1;
                            cnt_load_val = cfg_wid_m1;
                        end
                    end
                end
                ST_HIGH: begin
                    if (!cnt_zero) begin
                        cnt_en = 1'b1;
                    end else if (idx_q == num_q - IDX_ONE) begin
                        // Last pulse: d falls, done fires and busy drops together.
                        state_d = ST_IDLE;
                        d_d     = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = ST_LOW;
                        d_d          = 1'b0;
                        cnt_load     = 1'b1;
                        cnt_load_val = gap_m1_q;
                    end
                end
                ST_LOW: begin
                    if (!cnt_zero) begin
                        cnt_en = 1'b1;
                    end else begin
                        state_d      = ST_HIGH;
                        d_d          = 1'b1;
                        idx_d        = idx_q + IDX_ONE;
                        cnt_load     = 1'b1;
                        cnt_load_val = wid_m1_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    d_d     = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            d_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            idx_q    <= '0;
            wid_m1_q <= '0;
            gap_m1_q <= '0;
            num_q    <= '0;
        end else begin
            state_q  <= state_d;
            d_q      <= d_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            idx_q    <= idx_d;
            wid_m1_q <= wid_m1_d;
            gap_m1_q <= gap_m1_d;
            num_q    <= num_d;
        end
    end

    assign bus.d         = d_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pulse_idx = idx_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: table of burst configurations with
// expected high-cycle count and done cycle, per-cycle comparison against a
// waveform list built from the burst rules, plus hand sequences for re-trigger,
// abort and asynchronous reset, and a randomized burst loop.
module tb_pulse_train_gen;
    import edge_pkg::*;

    localparam int CNT_W = 8;
    localparam int NUM_W = 4;
    localparam int EW    = NUM_W + 3;   // {d, busy, done, pulse_idx}

    logic clk;
    logic rst_n;

    pulse_train_gen_if #(.CNT_W(CNT_W), .NUM_W(NUM_W)) bus ();

    pulse_train_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0]    exp_q[$];
    logic [NUM_W-1:0] model_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs per cycle after the trig-sampling edge, derived from the
    // burst description: pulses of W' ones, gaps of G' zeros, then one done cycle.
    task automatic model_build(input int w, input int g, input int n);
        int wl;
        int gl;
        logic [NUM_W-1:0] p4;
        wl = (w == 0) ? 1 : w;
        gl = (g == 0) ? 1 : g;
        exp_q.delete();
        if (n == 0) begin
            exp_q.push_back({3'b001, model_idx});
        end else begin
            for (int p = 0; p < n; p++) begin
                p4 = p[NUM_W-1:0];
                for (int k = 0; k < wl; k++) exp_q.push_back({3'b110, p4});
                if (p != n - 1)
                    for (int k = 0; k < gl; k++) exp_q.push_back({3'b010, p4});
            end
            p4 = n - 1;
            exp_q.push_back({3'b001, p4});
            model_idx = p4;
        end
    endtask

    // Drives trig "now" (away from a clock edge) and checks every following cycle.
    // trig_cyc: cycle in which a stray trig with random cfg is driven (0 = none).
    // abort_cyc: cycle in which abort is driven (0 = none).
    task automatic run_burst(input string tag, input int w, input int g, input int n,
                             input int trig_cyc, input int abort_cyc, input int n_idle,
                             output int high_cnt, output int done_cyc);
        logic [EW-1:0]    e;
        logic [NUM_W-1:0] hold_idx;
        logic [31:0]      exp_state;
        int len;
        model_build(w, g, n);
        if (abort_cyc > 0 && abort_cyc <= exp_q.size()) begin
            hold_idx = exp_q[abort_cyc-1][NUM_W-1:0];
            for (int i = abort_cyc; i < exp_q.size(); i++) exp_q[i] = {3'b000, hold_idx};
            model_idx = hold_idx;
        end
        for (int i = 0; i < n_idle; i++) exp_q.push_back({3'b000, model_idx});
        bus.cfg_width = w[CNT_W-1:0];
        bus.cfg_gap   = g[CNT_W-1:0];
        bus.cfg_num   = n[NUM_W-1:0];
        bus.trig      = 1'b1;
        bus.abort     = 1'b0;
        high_cnt = 0;
        done_cyc = 0;
        len = exp_q.size();
        for (int c = 1; c <= len; c++) begin
            @(posedge clk);
            #1;
            bus.trig  = (c == trig_cyc);
            bus.abort = (c == abort_cyc);
            if (c == trig_cyc) begin
                bus.cfg_width = CNT_W'($urandom_range(0, 255));
                bus.cfg_gap   = CNT_W'($urandom_range(0, 255));
                bus.cfg_num   = NUM_W'($urandom_range(0, 15));
            end
            @(negedge clk);
            e = exp_q.pop_front();
            exp_state = !e[NUM_W+1] ? 32'(ST_IDLE) : (e[NUM_W+2] ? 32'(ST_HIGH) : 32'(ST_LOW));
            check($sformatf("%s c%0d d", tag, c),     32'(bus.d),         32'(e[NUM_W+2]));
            check($sformatf("%s c%0d busy", tag, c),  32'(bus.busy),      32'(e[NUM_W+1]));
            check($sformatf("%s c%0d done", tag, c),  32'(bus.done),      32'(e[NUM_W]));
            check($sformatf("%s c%0d idx", tag, c),   32'(bus.pulse_idx), 32'(e[NUM_W-1:0]));
            check($sformatf("%s c%0d state", tag, c), 32'(bus.state_dbg), exp_state);
            if (bus.d) high_cnt++;
            if (bus.done && done_cyc == 0) done_cyc = c;
        end
        bus.trig  = 1'b0;
        bus.abort = 1'b0;
    endtask

    typedef struct {
        int w;
        int g;
        int n;
        int exp_high;
        int exp_done;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int hc;
        int dc;

        vecs[0] = '{3,   2,   2,  6,   9};
        vecs[1] = '{0,   0,   3,  3,   6};
        vecs[2] = '{0,   5,   0,  0,   1};
        vecs[3] = '{1,   1,   1,  1,   2};
        vecs[4] = '{4,   1,   3, 12,  15};
        vecs[5] = '{2,   3,  15, 30,  73};
        vecs[6] = '{1,   0,   1,  1,   2};
        vecs[7] = '{255, 1,   1, 255, 256};
        vecs[8] = '{1,   255, 2,  2,  258};

        // ---------------- reset ----------------
        rst_n         = 1'b0;
        bus.trig      = 1'b0;
        bus.abort     = 1'b0;
        bus.cfg_width = '0;
        bus.cfg_gap   = '0;
        bus.cfg_num   = '0;
        model_idx     = '0;
        repeat (3) @(negedge clk);
        check("reset d",     32'(bus.d),         0);
        check("reset busy",  32'(bus.busy),      0);
        check("reset done",  32'(bus.done),      0);
        check("reset idx",   32'(bus.pulse_idx), 0);
        check("reset state", 32'(bus.state_dbg), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- table ----------------
        for (int i = 0; i < 9; i++) begin
            run_burst($sformatf("vec%0d", i), vecs[i].w, vecs[i].g, vecs[i].n, 0, 0, 1, hc, dc);
            check($sformatf("vec%0d high", i), 32'(hc), 32'(vecs[i].exp_high));
            check($sformatf("vec%0d done_cyc", i), 32'(dc), 32'(vecs[i].exp_done));
        end

        // ---------------- stray trig + cfg change mid-burst, then re-trig on done ----------------
        run_burst("ignore", 3, 2, 2, 4, 0, 0, hc, dc);
        check("ignore high", 32'(hc), 6);
        check("ignore done_cyc", 32'(dc), 9);
        run_burst("retrig", 3, 2, 2, 0, 0, 1, hc, dc);
        check("retrig high", 32'(hc), 6);
        check("retrig done_cyc", 32'(dc), 9);

        // ---------------- abort ----------------
        run_burst("abort", 3, 2, 2, 0, 4, 2, hc, dc);
        check("abort high", 32'(hc), 3);
        check("abort no done", 32'(dc), 0);
        check("abort idx", 32'(bus.pulse_idx), 0);

        bus.cfg_width = 8'd3;
        bus.cfg_gap   = 8'd2;
        bus.cfg_num   = 4'd2;
        bus.trig      = 1'b1;
        bus.abort     = 1'b1;
        @(posedge clk);
        #1;
        bus.trig  = 1'b0;
        bus.abort = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("abort+trig c%0d d", c),    32'(bus.d),    0);
            check($sformatf("abort+trig c%0d busy", c), 32'(bus.busy), 0);
            check($sformatf("abort+trig c%0d done", c), 32'(bus.done), 0);
        end

        // ---------------- async reset mid-HIGH ----------------
        bus.trig = 1'b1;
        @(posedge clk);
        #1;
        bus.trig = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst pre d", 32'(bus.d), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst async d",     32'(bus.d),         0);
        check("rst async busy",  32'(bus.busy),      0);
        check("rst async done",  32'(bus.done),      0);
        check("rst async idx",   32'(bus.pulse_idx), 0);
        check("rst async state", 32'(bus.state_dbg), 32'(ST_IDLE));
        @(negedge clk);
        rst_n     = 1'b1;
        model_idx = '0;
        @(negedge clk);
        run_burst("post_rst", 3, 2, 2, 0, 0, 1, hc, dc);
        check("post_rst high", 32'(hc), 6);
        check("post_rst done_cyc", 32'(dc), 9);

        // ---------------- randomized bursts ----------------
        for (int r = 0; r < 25; r++) begin
            run_burst($sformatf("rnd%0d", r),
                      int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 5)), 0, 0, int'($urandom_range(0, 2)), hc, dc);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
